// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared sizing and state encoding for the FFT result collector
package fft_pkg;

    localparam int FFT_NPOINT = 32;
    localparam int FFT_DW     = 17;
    localparam int FFT_IDX_W  = $clog2(FFT_NPOINT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/fft_bin_buffer.sv
// rtl/fft_bin_buffer.sv - NPOINT x 2*DW bin store, one write port, one registered read port
module fft_bin_buffer
    import fft_pkg::*;
#(
    parameter int DEPTH = FFT_NPOINT,
    parameter int WIDTH = 2 * FFT_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: contents are not cleared by reset, only overwritten by new frames
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; cleared on reset so the presented bin reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_result_collector.sv
// rtl/fft_result_collector.sv - collects bit-reversed FFT words and drains bins in natural order
module fft_result_collector
    import fft_pkg::*;
#(
    parameter int NPOINT = FFT_NPOINT,
    parameter int DW     = FFT_DW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      finish,
    input  logic [DW-1:0]             answer,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW-1:0]             out_re,
    output logic [DW-1:0]             out_im,
    output logic [$clog2(NPOINT)-1:0] out_idx,
    output logic                      frame_done,
    output logic                      overrun
);

    localparam int IW = $clog2(NPOINT);
    localparam int CW = IW + 1;

    state_t           state;
    logic [CW-1:0]    word_cnt;
    logic [DW-1:0]    re_hold;

    logic             capture;
    logic             last_word;
    logic             xfer;
    logic             last_xfer;

    logic             wr_en;
    logic [IW-1:0]    wr_addr;
    logic [2*DW-1:0]  wr_data;
    logic             rd_en;
    logic [IW-1:0]    rd_addr;
    logic [2*DW-1:0]  rd_data;

    function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] v);
        logic [IW-1:0] r;
        for (int i = 0; i < IW; i++) begin
            r[i] = v[IW-1-i];
        end
        return r;
    endfunction

    // Words are only taken outside DRAIN; anything arriving while draining is an overrun
    assign capture   = finish && (state != ST_DRAIN);
    assign last_word = capture && (word_cnt == CW'(2 * NPOINT - 1));
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && (out_idx == IW'(NPOINT - 1));

    // Odd words complete a bin; store it at its natural-order address
    always_comb begin
        wr_en   = capture && word_cnt[0];
        wr_addr = bitrev(word_cnt[CW-1:1]);
        wr_data = {re_hold, answer};
    end

    // Prefetch bin 0 on DRAIN entry, then the next bin on each non-final transfer
    always_comb begin
        rd_en   = ((state == ST_DRAIN) && !out_valid) || (xfer && !last_xfer);
        rd_addr = out_valid ? (out_idx + IW'(1)) : '0;
    end

    // Collector state machine with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            word_cnt   <= '0;
            re_hold    <= '0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (capture) begin
                if (!word_cnt[0]) begin
                    re_hold <= answer;
                end
                word_cnt <= last_word ? '0 : word_cnt + CW'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (capture) begin
                        state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (last_word) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (finish) begin
                        overrun <= 1'b1;
                    end
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                    end else if (xfer) begin
                        if (last_xfer) begin
                            out_valid  <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            out_idx <= out_idx + IW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_re = rd_data[2*DW-1:DW];
    assign out_im = rd_data[DW-1:0];

    fft_bin_buffer #(
        .DEPTH (NPOINT),
        .WIDTH (2 * DW)
    ) u_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
